// File: rtl/hazard_defs.sv
// rtl/hazard_defs.sv - shared encodings and forwarding helper for the hazard unit
package hazard_defs;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mem_state_t;

  // r15 reads the PC, so it is never a forwarding target
  function automatic logic [1:0] fwd_sel(
    input logic [3:0] ra,
    input logic [3:0] wa_m,
    input logic       we_m,
    input logic [3:0] wa_w,
    input logic       we_w
  );
    if (we_m && (wa_m == ra) && (ra != 4'd15)) return FWD_M;
    if (we_w && (wa_w == ra) && (ra != 4'd15)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// rtl/mem_wait_fsm.sv - data-memory wait-state tracker with timeout and sticky error
module mem_wait_fsm import hazard_defs::*; #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_access,
  input  logic mem_ack,
  output logic mem_req,
  output logic memstall,
  output logic mem_err
);

  mem_state_t state;
  logic [7:0] wait_cnt;
  logic       timeout;

  assign timeout = (state == S_WAIT) && (wait_cnt >= 8'(MAX_WAIT)) && !mem_ack;

  always_comb begin
    mem_req  = 1'b0;
    memstall = 1'b0;
    if (reset) begin
      mem_req = mem_access;
      if (state == S_IDLE) memstall = mem_access && !mem_ack;
      else                 memstall = !mem_ack && !timeout;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_access && !mem_ack) begin
            state    <= S_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            state <= S_IDLE;
          end else if (timeout) begin
            // abandon the access; the loaded value is garbage from here on
            state   <= S_IDLE;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - forwarding, stall and flush control for the 5-stage pipeline
module hazard_unit import hazard_defs::*; #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemAccessM,
  input  logic             PCWrPendingF,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             mem_ack,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  logic ldrstall;
  logic memstall;

  assign ldrstall = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));

  mem_wait_fsm #(.MAX_WAIT(MAX_WAIT)) u_mem_wait (
    .clk        (clk),
    .reset      (reset),
    .mem_access (MemAccessM),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .memstall   (memstall),
    .mem_err    (mem_err)
  );

  // Flushes are masked during a memory freeze; the frozen stages re-present the cause later
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    if (reset) begin
      ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
      ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);
      StallF    = ldrstall || PCWrPendingF || memstall;
      StallD    = ldrstall || memstall;
      StallE    = memstall;
      StallM    = memstall;
      StallW    = memstall;
      FlushD    = (PCWrPendingF || PCSrcW || BranchTakenE) && !memstall;
      FlushE    = (ldrstall || BranchTakenE) && !memstall;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (StallF && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;
  import hazard_defs::*;

  localparam int MAXW = 4;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic RegWriteM, RegWriteW, MemtoRegE, MemAccessM, PCWrPendingF, PCSrcW, BranchTakenE, mem_ack;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_req, mem_err;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad = 0;

  int m_age = 0;
  int m_cnt = 0;
  logic m_err = 1'b0;
  logic [1:0] e_fa, e_fb;
  logic e_sf, e_sd, e_se, e_fd, e_fe, e_req;

  always #5 clk = ~clk;

  hazard_unit #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .MemAccessM(MemAccessM), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .mem_ack(mem_ack),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .mem_req(mem_req), .mem_err(mem_err),
    .stall_cycles(stall_cycles)
  );

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'd0;
    if (RegWriteM && WA3M == ra) return 2'd2;
    if (RegWriteW && WA3W == ra) return 2'd1;
    return 2'd0;
  endfunction

  // m_age = cycles the current access has spent outstanding after its first cycle (0: none)
  function automatic void eval_model();
    logic ms, ld;
    ld = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
    if (m_age == 0) ms = MemAccessM && !mem_ack;
    else            ms = !mem_ack && (m_age < MAXW);
    e_fa  = fwd(RA1E);
    e_fb  = fwd(RA2E);
    e_sf  = ld || PCWrPendingF || ms;
    e_sd  = ld || ms;
    e_se  = ms;
    e_fd  = (PCWrPendingF || PCSrcW || BranchTakenE) && !ms;
    e_fe  = (ld || BranchTakenE) && !ms;
    e_req = MemAccessM;
    if (!reset) begin
      e_fa = 2'd0; e_fb = 2'd0; e_sf = 0; e_sd = 0; e_se = 0;
      e_fd = 1; e_fe = 1; e_req = 0;
    end
  endfunction

  task automatic advance();
    eval_model();
    @(posedge clk);
    if (reset) begin
      if (e_sf && m_cnt < (1 << CW) - 1) m_cnt++;
      if (m_age == 0) begin
        if (MemAccessM && !mem_ack) m_age = 1;
      end else if (mem_ack) m_age = 0;
      else if (m_age >= MAXW) begin m_age = 0; m_err = 1'b1; end
      else m_age++;
    end
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E} = 16'h0123;
    {WA3E, WA3M, WA3W} = 12'h987;
    {RegWriteM, RegWriteW, MemtoRegE, MemAccessM} = 4'b0;
    {PCWrPendingF, PCSrcW, BranchTakenE, mem_ack} = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_age = 0; m_cnt = 0; m_err = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    MemAccessM = 1'b1; RegWriteM = 1'b1; WA3M = 4'd1; RA1E = 4'd1;
    #3;
    total++;
    if ({mem_req, StallF, StallD, StallE, StallM, StallW} !== 6'b0) begin
      bad++; $display("FAIL reset_stalls: got %b want 000000", {mem_req, StallF, StallD, StallE, StallM, StallW});
    end
    total++;
    if ({FlushD, FlushE, ForwardAE, ForwardBE} !== 6'b110000) begin
      bad++; $display("FAIL reset_flush_fwd: got %b want 110000", {FlushD, FlushE, ForwardAE, ForwardBE});
    end
    total++;
    if (mem_err !== 1'b0 || stall_cycles !== 4'd0) begin
      bad++; $display("FAIL reset_regs: mem_err=%b stall_cycles=%0d want 0 0", mem_err, stall_cycles);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    clear_inputs();
  endtask

  task automatic test_forward();
    clear_inputs();
    RegWriteM = 1; WA3M = 4'd3; RA1E = 4'd3; RA2E = 4'd3; RegWriteW = 1; WA3W = 4'd3;
    @(negedge clk);
    total++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
      bad++; $display("FAIL fwd_m_prio: got %b/%b want 10/10", ForwardAE, ForwardBE);
    end
    RegWriteM = 0;
    #1;
    total++;
    if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin
      bad++; $display("FAIL fwd_w: got %b/%b want 01/01", ForwardAE, ForwardBE);
    end
    RegWriteM = 1; WA3M = 4'd15; WA3W = 4'd15; RA1E = 4'd15;
    #1;
    total++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      bad++; $display("FAIL fwd_r15: got %b/%b want 00/00", ForwardAE, ForwardBE);
    end
    advance();
    clear_inputs();
  endtask

  task automatic test_ldrstall();
    clear_inputs();
    MemtoRegE = 1; WA3E = 4'd5; RA2D = 4'd5;
    @(negedge clk);
    total++;
    if ({StallF, StallD, FlushE, StallE} !== 4'b1110) begin
      bad++; $display("FAIL ldrstall: got F,D,FlushE,E=%b want 1110", {StallF, StallD, FlushE, StallE});
    end
    advance();
    MemtoRegE = 0;
    @(negedge clk);
    total++;
    if ({StallF, StallD, FlushE, StallE} !== 4'b0000) begin
      bad++; $display("FAIL ldrstall_clear: got %b want 0000", {StallF, StallD, FlushE, StallE});
    end
    advance();
  endtask

  task automatic test_mem_wait();
    do_reset();
    clear_inputs();
    MemAccessM = 1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      @(negedge clk);
      total++;
      if ({mem_req, StallF, StallD, StallE, StallM, StallW} !== {1'b1, {5{i < 3}}}) begin
        bad++; $display("FAIL mem_wait_c%0d: got req,stalls=%b want %b", i,
          {mem_req, StallF, StallD, StallE, StallM, StallW}, {1'b1, {5{i < 3}}});
      end
      advance();
    end
    clear_inputs();
    @(negedge clk);
    total++;
    if (stall_cycles !== 4'd3) begin
      bad++; $display("FAIL mem_wait_count: got %0d want 3", stall_cycles);
    end
    advance();
  endtask

  task automatic test_branch_flush();
    do_reset();
    clear_inputs();
    MemAccessM = 1; BranchTakenE = 1;
    for (int i = 0; i < 3; i++) begin
      mem_ack = (i == 2);
      @(negedge clk);
      total++;
      if ({FlushD, FlushE, StallF} !== ((i == 2) ? 3'b110 : 3'b001)) begin
        bad++; $display("FAIL branch_flush_c%0d: got FlushD,FlushE,StallF=%b want %b", i,
          {FlushD, FlushE, StallF}, (i == 2) ? 3'b110 : 3'b001);
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    clear_inputs();
    MemAccessM = 1;
    for (int i = 0; i <= MAXW; i++) begin
      @(negedge clk);
      total++;
      if (StallW !== (i < MAXW) || mem_err !== 1'b0) begin
        bad++; $display("FAIL timeout_c%0d: StallW=%b mem_err=%b want %b 0", i, StallW, mem_err, i < MAXW);
      end
      advance();
    end
    clear_inputs();
    @(negedge clk);
    total++;
    if (mem_err !== 1'b1 || stall_cycles !== 4'(MAXW)) begin
      bad++; $display("FAIL timeout_err: mem_err=%b stall_cycles=%0d want 1 %0d", mem_err, stall_cycles, MAXW);
    end
    for (int i = 0; i < 3; i++) advance();
    total++;
    if (mem_err !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky: mem_err=%b want 1", mem_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    MemAccessM = 1;
    advance();
    advance();
    total++;
    if (StallE !== 1'b1 || mem_err !== 1'b1) begin
      bad++; $display("FAIL midwait_pre: StallE=%b mem_err=%b want 1 1", StallE, mem_err);
    end
    #2;
    reset = 1'b0;
    m_age = 0; m_cnt = 0; m_err = 1'b0;
    #1;
    total++;
    if ({mem_req, FlushD, FlushE, StallF, mem_err} !== 5'b01100 || stall_cycles !== 4'd0) begin
      bad++; $display("FAIL midwait_async: req,FlushD,FlushE,StallF,err=%b cnt=%0d want 01100 0",
        {mem_req, FlushD, FlushE, StallF, mem_err}, stall_cycles);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    MemAccessM = 0;
    @(negedge clk);
    total++;
    if (StallE !== 1'b0 || mem_req !== 1'b0 || FlushD !== 1'b0) begin
      bad++; $display("FAIL midwait_idle: StallE=%b req=%b FlushD=%b want 0 0 0", StallE, mem_req, FlushD);
    end
    advance();
  endtask

  task automatic test_saturate();
    do_reset();
    clear_inputs();
    PCWrPendingF = 1;
    for (int i = 0; i < 20; i++) advance();
    PCWrPendingF = 0;
    @(negedge clk);
    total++;
    if (stall_cycles !== 4'hF) begin
      bad++; $display("FAIL saturate: got %0d want 15", stall_cycles);
    end
    advance();
  endtask

  function automatic logic [3:0] rreg();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    logic hold;
    logic [16:0] got, exp;
    hold = 1'b0;
    do_reset();
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg();
        WA3E = rreg(); WA3M = rreg(); WA3W = rreg();
        RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
        MemtoRegE = ($urandom_range(0, 3) == 0);
        MemAccessM = 1'($urandom);
        PCWrPendingF = ($urandom_range(0, 5) == 0);
        PCSrcW = ($urandom_range(0, 7) == 0);
        BranchTakenE = ($urandom_range(0, 5) == 0);
      end
      mem_ack = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      eval_model();
      got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
             FlushD, FlushE, mem_req, mem_err, stall_cycles};
      exp = {e_fa, e_fb, e_sf, e_sd, e_se, e_se, e_se, e_fd, e_fe, e_req, m_err, 4'(m_cnt)};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random_c%0d: got %b want %b", i, got, exp);
      end
      hold = e_se;
      advance();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_ldrstall();
    test_mem_wait();
    test_branch_flush();
    test_timeout();
    test_reset_mid_wait();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
